// File: rtl/qspi_xip_pkg.sv
// Shared types and constants for the AHB-to-QSPI execute-in-place read controller.
package qspi_xip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    DONE
  } xip_state_e;

  // SCK cycles spent in each phase of a Fast-Read-Quad-I/O transaction
  localparam logic [3:0] CMD_CYC  = 4'd8;
  localparam logic [3:0] ADDR_CYC = 4'd6;
  localparam logic [3:0] MODE_CYC = 4'd2;
  localparam logic [3:0] DATA_CYC = 4'd8;

  localparam int unsigned DEF_DUMMY_CLKS = 4;
  localparam logic [7:0]  DEF_OPCODE     = 8'hEB;
  localparam logic [7:0]  DEF_MODE       = 8'hFF;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ahb_qspi_xip_ctrl_if.sv
// AHB-Lite read-slot signals of the flash region, grouped for the XIP controller.
interface ahb_qspi_xip_ctrl_if;

  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HREADY, HTRANS, HWRITE, HADDR,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HTRANS, HWRITE, HADDR,
    output HREADYOUT, HRDATA
  );

endinterface

// File: rtl/qspi_xip_shifter.sv
// SCK = HCLK/2 generator with command/address shift-out, nibble shift-in and phase cycle counter.
module qspi_xip_shifter
  import qspi_xip_pkg::*;
#(
  parameter logic [7:0] CMD_OPCODE = DEF_OPCODE,
  parameter logic [7:0] MODE_BYTE  = DEF_MODE
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [23:0] addr,
  input  xip_state_e  state,
  input  logic [3:0]  cnt_ld,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic        douten,
  output logic        sck,
  output logic        cyc_end,
  output logic        xfer_end,
  output logic [31:0] rx_word
);

  logic        run;
  logic        ph;
  logic        rx_done;
  logic [3:0]  cnt;
  logic [7:0]  cmd_sr;
  logic [31:0] tx_sr;

  assign run      = state inside {CMD, ADDR, MODE, DUMMY, DATA};
  assign cyc_end  = run && ph && !rx_done && (cnt == 4'd0);
  assign xfer_end = run && ph && rx_done;

  // ph=0: next edge drives sck low and shifts out; ph=1: next edge drives sck high and samples din
  always_ff @(posedge HCLK) begin
    if (HRESET || (!start && !run)) begin
      ph      <= 1'b0;
      rx_done <= 1'b0;
      sck     <= 1'b0;
      dout    <= 4'h0;
      douten  <= 1'b0;
      cnt     <= 4'd0;
      cmd_sr  <= 8'h00;
      tx_sr   <= 32'h0;
      if (HRESET) rx_word <= 32'h0;
    end else if (start) begin
      ph      <= 1'b0;
      rx_done <= 1'b0;
      sck     <= 1'b0;
      cnt     <= CMD_CYC - 4'd1;
      cmd_sr  <= CMD_OPCODE;
      tx_sr   <= {addr, MODE_BYTE};
    end else if (!ph) begin
      sck    <= 1'b0;
      ph     <= 1'b1;
      douten <= state inside {CMD, ADDR, MODE};
      case (state)
        CMD: begin
          dout   <= {3'b110, cmd_sr[7]};
          cmd_sr <= {cmd_sr[6:0], 1'b0};
        end
        ADDR, MODE: begin
          dout  <= tx_sr[31:28];
          tx_sr <= {tx_sr[27:0], 4'h0};
        end
        default: dout <= 4'h0;
      endcase
    end else if (!rx_done) begin
      sck <= 1'b1;
      ph  <= 1'b0;
      if (state == DATA) rx_word <= {rx_word[27:0], din};
      if (cnt == 4'd0) begin
        cnt <= cnt_ld;
        if (state == DATA) rx_done <= 1'b1;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/ahb_qspi_xip_ctrl.sv
// Read-only AHB-Lite slave: each accepted read fetches one 32-bit word via a quad I/O 0xEB flash read.
module ahb_qspi_xip_ctrl
  import qspi_xip_pkg::*;
#(
  parameter logic [7:0]  CMD_OPCODE = DEF_OPCODE,
  parameter logic [7:0]  MODE_BYTE  = DEF_MODE,
  parameter int unsigned DUMMY_CLKS = DEF_DUMMY_CLKS
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahb_qspi_xip_ctrl_if.slave ahb,
  input  logic [3:0]         din,
  output logic [3:0]         dout,
  output logic               douten,
  output logic               sck,
  output logic               ce_n
);

  // state | meaning
  // IDLE  | no transfer, bus ready
  // CMD   | opcode shifted serially on dout[0]
  // ADDR  | 24-bit word address, one nibble per SCK
  // MODE  | mode byte, continuous read left disabled
  // DUMMY | bus turnaround, outputs released
  // DATA  | eight nibbles captured, then one closing SCK-low cycle
  // DONE  | word returned, ce_n high, new read may be accepted

  localparam logic [3:0] DUMMY_LD = 4'(DUMMY_CLKS - 1);

  xip_state_e  state, state_nxt;
  logic        accept;
  logic        start;
  logic        cyc_end;
  logic        xfer_end;
  logic [3:0]  cnt_ld;
  logic [31:0] rx_word;
  logic [31:0] hrdata_q;
  logic        unused_ahb;

  assign accept     = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & ~ahb.HWRITE;
  assign start      = accept && (state == IDLE || state == DONE);
  assign unused_ahb = ^{ahb.HADDR[31:24], ahb.HADDR[1:0], ahb.HTRANS[0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_ld    = 4'd0;
    case (state)
      IDLE:  if (start) state_nxt = CMD;
      CMD:   if (cyc_end) begin state_nxt = ADDR;  cnt_ld = ADDR_CYC - 4'd1; end
      ADDR:  if (cyc_end) begin state_nxt = MODE;  cnt_ld = MODE_CYC - 4'd1; end
      MODE:  if (cyc_end) begin state_nxt = DUMMY; cnt_ld = DUMMY_LD;        end
      DUMMY: if (cyc_end) begin state_nxt = DATA;  cnt_ld = DATA_CYC - 4'd1; end
      DATA:  if (xfer_end) state_nxt = DONE;
      DONE:  state_nxt = start ? CMD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ahb.HREADYOUT = 1'b1;
    ce_n          = 1'b1;
    case (state)
      CMD, ADDR, MODE, DUMMY, DATA: begin
        ahb.HREADYOUT = 1'b0;
        ce_n          = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET)                         hrdata_q <= 32'h0;
    else if (state == DATA && xfer_end) hrdata_q <= bswap32(rx_word);
  end

  assign ahb.HRDATA = hrdata_q;

  qspi_xip_shifter #(
    .CMD_OPCODE (CMD_OPCODE),
    .MODE_BYTE  (MODE_BYTE)
  ) u_shifter (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .start    (start),
    .addr     ({ahb.HADDR[23:2], 2'b00}),
    .state    (state),
    .cnt_ld   (cnt_ld),
    .din      (din),
    .dout     (dout),
    .douten   (douten),
    .sck      (sck),
    .cyc_end  (cyc_end),
    .xfer_end (xfer_end),
    .rx_word  (rx_word)
  );

endmodule

// File: tb/tb_ahb_qspi_xip_ctrl.sv
// Directed bench for the XIP controller with a small behavioural quad-read flash model.
module tb_ahb_qspi_xip_ctrl;

  logic        HCLK;
  logic        HRESET;
  logic [3:0]  din = 4'h0;
  logic [3:0]  dout;
  logic        douten;
  logic        sck;
  logic        ce_n;

  ahb_qspi_xip_ctrl_if ahb();

  ahb_qspi_xip_ctrl dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .ahb    (ahb),
    .din    (din),
    .dout   (dout),
    .douten (douten),
    .sck    (sck),
    .ce_n   (ce_n)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [16];
  logic [3:0] cap_d  [32];
  logic       cap_oe [32];
  int         n_rise = 0;
  logic       sck_q  = 1'b0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // capture what the flash sees on each SCK rising edge
  always @(posedge HCLK) begin
    #1;
    if (ce_n) begin
      n_rise = 0;
    end else if (sck && !sck_q && n_rise < 32) begin
      cap_d[n_rise]  = dout;
      cap_oe[n_rise] = douten;
      n_rise++;
    end
    sck_q = sck;
  end

  function automatic logic [3:0] flash_nib(input int k);
    logic [23:0] fa;
    logic [7:0]  b;
    int          j;
    int          idx;
    if (k < 20 || k > 27) return 4'h0;
    fa  = {cap_d[8], cap_d[9], cap_d[10], cap_d[11], cap_d[12], cap_d[13]};
    j   = k - 20;
    idx = (int'(fa[3:0]) + j / 2) % 16;
    b   = mem[idx];
    return (j % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  always @(negedge HCLK) din = flash_nib(n_rise);

  task automatic ahb_read(input logic [31:0] a, output int waits);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = a;
    @(posedge HCLK); #1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    waits = 0;
    while (ahb.HREADYOUT == 1'b0 && waits < 200) begin
      waits++;
      @(posedge HCLK); #1;
    end
  endtask

  int          w;
  int          guard;
  logic [7:0]  cmd_b;
  logic        hi_ok;
  logic        rdy_ok;
  logic        cs_ok;
  logic [15:0] oe;

  initial begin
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
    for (int i = 8; i < 16; i++) mem[i] = 8'(8'hA0 + i);

    HRESET     = 1'b1;
    ahb.HSEL   = 1'b0;
    ahb.HREADY = 1'b1;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_ce_n",      32'(ce_n),          32'd1);
    check("rst_sck",       32'(sck),           32'd0);
    check("rst_douten",    32'(douten),        32'd0);
    check("rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
    check("rst_hrdata",    ahb.HRDATA,         32'h0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    ahb_read(32'h0000_0000, w);
    check("single_waits", 32'(w),    32'd58);
    check("single_data",  ahb.HRDATA, 32'h4433_2211);
    @(posedge HCLK); #1;

    ahb_read(32'h0000_0106, w);
    cmd_b = 8'h00;
    hi_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_b = {cmd_b[6:0], cap_d[i][0]};
      if (cap_d[i][3:1] !== 3'b110) hi_ok = 1'b0;
    end
    for (int i = 0; i < 16; i++) oe[15-i] = cap_oe[i];
    check("wave_waits",   32'(w),     32'd58);
    check("wave_cmd",     32'(cmd_b), 32'h0000_00EB);
    check("wave_cmd_hi",  32'(hi_ok), 32'd1);
    check("wave_addr",    32'({cap_d[8], cap_d[9], cap_d[10], cap_d[11], cap_d[12], cap_d[13]}), 32'h0000_0104);
    check("wave_mode",    32'({cap_d[14], cap_d[15]}), 32'h0000_00FF);
    check("wave_oe_on",   32'(oe),    32'h0000_FFFF);
    check("wave_oe_dmy",  32'(cap_oe[16]), 32'd0);
    check("wave_data",    ahb.HRDATA, 32'h8877_6655);
    @(posedge HCLK); #1;

    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b1;
    ahb.HADDR  = 32'h0;
    rdy_ok = 1'b1;
    cs_ok  = 1'b1;
    repeat (4) begin
      @(posedge HCLK); #1;
      if (ahb.HREADYOUT !== 1'b1) rdy_ok = 1'b0;
      if (ce_n !== 1'b1)          cs_ok  = 1'b0;
    end
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
    check("wr_hreadyout", 32'(rdy_ok), 32'd1);
    check("wr_ce_n",      32'(cs_ok),  32'd1);
    check("wr_hrdata",    ahb.HRDATA,  32'h8877_6655);
    @(posedge HCLK); #1;

    ahb_read(32'h0000_0000, w);
    check("b2b0_waits", 32'(w),     32'd58);
    check("b2b0_data",  ahb.HRDATA, 32'h4433_2211);
    check("b2b_gap",    32'(ce_n),  32'd1);
    ahb_read(32'h0000_0004, w);
    check("b2b1_waits", 32'(w),     32'd58);
    check("b2b1_data",  ahb.HRDATA, 32'h8877_6655);
    @(posedge HCLK); #1;

    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = 32'h0;
    @(posedge HCLK); #1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    guard = 0;
    while (n_rise < 22 && guard < 200) begin
      @(posedge HCLK); #1;
      guard++;
    end
    check("mid_in_data", 32'(n_rise >= 22), 32'd1);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    check("mid_ce_n",      32'(ce_n),          32'd1);
    check("mid_sck",       32'(sck),           32'd0);
    check("mid_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
    check("mid_douten",    32'(douten),        32'd0);
    check("mid_hrdata",    ahb.HRDATA,         32'h0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    ahb_read(32'h0000_0000, w);
    check("post_waits", 32'(w),     32'd58);
    check("post_data",  ahb.HRDATA, 32'h4433_2211);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
